// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle processor control path: FSM states,
// instruction opcodes/functs, ALU function selects and ALU-op classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-op class and the R-type funct field to the ALU
// function select; flags functs the ALU cannot execute.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       legal
);

    // funct decode only matters for ALUOP_FUNCT; fixed ops are always legal
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    FUNCT_MUL: begin
                        alu_control = MUL_EN ? ALU_MUL : ALU_AND;
                        legal       = MUL_EN;
                    end
                    default: begin
                        alu_control = ALU_AND;
                        legal       = 1'b0;
                    end
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle processor: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath selects/enables.
//
//   state         | meaning
//   --------------+--------------------------------------------------
//   FETCH    (0)  | read instr at PC, PC+4 -> PC when memory ready
//   DECODE   (1)  | branch target -> ALUOut, dispatch on op
//   MEMADR   (2)  | A + sign-ext imm -> ALUOut (lw/sw address)
//   MEMREAD  (3)  | read data at ALUOut, wait for memory ready
//   MEMWB    (4)  | data register -> rt
//   MEMWRITE (5)  | write B at ALUOut, wait for memory ready
//   EXECUTE  (6)  | R-type ALU operation
//   ALUWB    (7)  | ALUOut -> rd
//   BRANCH   (8)  | A - B, PC <- ALUOut when zero
//   ADDIEX   (9)  | A + sign-ext imm
//   ADDIWB   (10) | ALUOut -> rt
//   JUMP     (11) | PC <- jump target
//   12..15        | unreachable; FETCH muxes, no enables, back to FETCH
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter bit         MUL_EN      = 1'b1,
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       use_alu;
    logic [2:0] dec_control;
    logic       dec_legal;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       pc_write;
    logic       branch;
    logic       illegal_raw;

    alu_decoder #(.MUL_EN(MUL_EN)) u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alu_control(dec_control),
        .legal      (dec_legal)
    );

    // State register; reset returns to FETCH, abandoning any instruction
    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    // ALU-op class per state, kept apart from the main decode so the
    // decoder result feeds back without a combinational self-loop
    always_comb begin
        aluop   = ALUOP_ADD;
        use_alu = 1'b0;
        case (state_q)
            S_DECODE, S_MEMADR, S_ADDIEX: use_alu = 1'b1;
            S_EXECUTE: begin
                aluop   = ALUOP_FUNCT;
                use_alu = 1'b1;
            end
            S_BRANCH: begin
                aluop   = ALUOP_SUB;
                use_alu = 1'b1;
            end
            S_MEMREAD, S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_JUMP: use_alu = 1'b0;
            default: use_alu = 1'b1;
        endcase
    end

    // Next-state and datapath controls; unused selects stay 0
    always_comb begin
        state_d       = S_FETCH;
        iord          = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        illegal_raw   = 1'b0;
        alu_control   = use_alu ? dec_control : 3'b000;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                if (dec_legal) state_d = S_ALUWB;
                else           illegal_raw = 1'b1;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: alu_src_b = 2'b01;
        endcase
    end

    assign ir_write      = ir_write_raw & ~reset;
    assign mem_write     = mem_write_raw & ~reset;
    assign reg_write     = reg_write_raw & ~reset;
    assign pc_en         = (pc_write | (branch & zero)) & ~reset;
    assign illegal_instr = illegal_raw & ~reset;
    assign state_o       = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Main control FSM of the multicycle processor, directly upstream of the ALU. It decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the ALU function select F[2:0], the datapath mux selects and the write enables, and it consumes the ALU zero_flag for branch resolution. Memory accesses use a ready handshake so multi-cycle memories stall the FSM.

Parameters:
MUL_EN, 1, when 1 R-type funct 6'b011000 (mul) is legal and maps to F=3'b011; when 0 it is illegal
RESET_STATE, 4'd0, state encoding loaded on reset (FETCH); must not be changed

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero_flag (combinational, same cycle)
mem_ready  in  1  memory completed current read/write this cycle
iord  out  1  0: address=PC, 1: address=ALUOut
alu_src_a  out  1  0: PC, 1: reg A
alu_src_b  out  2  00: reg B, 01: constant 4, 10: sign-ext imm, 11: imm<<2
alu_control  out  3  ALU F[2:0]
pc_src  out  2  00: ALU result, 01: ALUOut, 10: jump target
mem_to_reg  out  1  writeback data: 0 ALUOut, 1 data register
reg_dst  out  1  dest: 0 rt, 1 rd
ir_write  out  1  load instruction register
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
pc_en  out  1  pc_write | (branch & zero)
illegal_instr  out  1  one-cycle pulse on undecodable instruction
state_o  out  4  current state, for debug/verification

Behaviour:
- State register updates on rising clk. reset=1 forces state to FETCH on the next edge. While reset=1, all write enables (ir_write, mem_write, reg_write, pc_en) and illegal_instr are forced 0 regardless of state. A reset mid-instruction abandons it with no partial writes after the reset edge.
- Outputs are combinational from state, plus mem_ready/zero where noted. Unlisted outputs are 0.
- FETCH (0): iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00. If mem_ready=1: ir_write=1, pc_en=1, go to DECODE. Otherwise stay, with ir_write=0 and pc_en=0.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op -> illegal_instr=1 this cycle, go to FETCH
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_control=010. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD (3): iord=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1, go to FETCH.
- MEMWRITE (5): iord=1, mem_write=1 held until mem_ready=1, then go to FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_control=decode(funct).
  - funct decode: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, 011000->011 (only if MUL_EN).
  - Any other funct: illegal_instr=1, go to FETCH with no writeback. Legal funct: go to ALUWB.
- ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1, go to FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1, so pc_en=zero. Go to FETCH.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_control=010, go to ADDIWB.
- ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1, go to FETCH.
- JUMP (11): pc_src=10, pc_en=1, go to FETCH.
- Encodings 12-15 are unreachable. If entered, they behave as FETCH with all enables 0 and go to FETCH.
- Latency with mem_ready=1 every cycle, in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one.

Decomposition:
- Package ctrl_pkg: state enum (4-bit, values above), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, and ALU F constants (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_MUL=011, ALU_SUB=110, ALU_SLT=111).
- Sub-module alu_decoder: combinational funct plus a 2-bit aluop (00 add, 01 sub, 10 funct) -> alu_control[2:0] and a legal flag.

Test Plan:
- lw, mem_ready=1 always -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1 and reg_dst=0.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total. ir_write pulses exactly once, on the ready cycle.
- R-type funct=011000, MUL_EN=1 -> alu_control=011 in EXECUTE, then ALUWB reg_write=1. With MUL_EN=0 -> illegal_instr pulse, back to FETCH, no reg_write.
- beq with zero=1 in BRANCH -> pc_en=1, pc_src=01. With zero=0 -> pc_en=0. Both take 3 cycles.
- op=6'b111111 -> illegal_instr=1 for one cycle in DECODE, then FETCH, with no write enables asserted.
- reset=1 during MEMWRITE with mem_ready=0 -> mem_write=0 that cycle, state_o=0 after the edge. Reset held 3 cycles -> all enables 0 throughout.
